led_clk_divider: RTL and testbench



---
 rtl/led_clk_divider.sv | 63 ++++++
 tb/tb_led_clk_divider.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_clk_divider.sv
// Refresh-clock generator: divides CLK_100MHz to a 50% duty CLK_LED.
// Optional LED_CLK_TICK_EN adds o_tick, a one-cycle pulse on each CLK_LED rise.
module led_clk_divider #(
    parameter int CLK_IN_HZ = 100_000_000,
    parameter int LED_HZ    = 1_000
) (
    input  logic CLK_100MHz,
    input  logic RST,
    input  logic i_ce,
`ifdef LED_CLK_TICK_EN
    output logic CLK_LED,
    output logic o_tick
`else
    output logic CLK_LED
`endif
);

    localparam int HALF   = CLK_IN_HZ / (2 * LED_HZ);
    localparam int HALF_S = (HALF < 1) ? 1 : HALF;
    localparam int CW     = (HALF_S > 1) ? $clog2(HALF_S) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_S - 1);

    if (HALF < 1) begin : g_bad_half
        $error("led_clk_divider: HALF must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic          led_q;
    logic          wrap;

    // Wrap only while enabled, so a frozen divider keeps its phase.
    assign wrap = i_ce && (cnt == LAST);

    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            led_q <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            led_q <= ~led_q;
        end else if (i_ce) begin
            cnt   <= cnt + CW'(1);
        end
    end

    assign CLK_LED = led_q;

`ifdef LED_CLK_TICK_EN
    logic tick_q;

    // Fires on the same edge led_q goes 0->1.
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap && !led_q;
        end
    end

    assign o_tick = tick_q;
`endif

endmodule

// File: tb/tb_led_clk_divider.sv
// Bench for led_clk_divider: HALF=4 and HALF=1 instances against an
// enabled-edge-count model, plus directed literal checks.
module tb_led_clk_divider;

    localparam int HA = 4;
    localparam int HB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    logic led_a;
    logic led_b;
    logic tick_a;
    logic tick_b;

    int checks = 0;
    int errors = 0;

    int   e    = 0;
    logic tk_a = 1'b0;
    logic tk_b = 1'b0;

    always #5 clk = ~clk;

`ifdef LED_CLK_TICK_EN
    led_clk_divider #(.CLK_IN_HZ(8), .LED_HZ(1)) dut_a (
        .CLK_100MHz(clk), .RST(rst), .i_ce(ce),
        .CLK_LED(led_a), .o_tick(tick_a)
    );
    led_clk_divider #(.CLK_IN_HZ(2), .LED_HZ(1)) dut_b (
        .CLK_100MHz(clk), .RST(rst), .i_ce(ce),
        .CLK_LED(led_b), .o_tick(tick_b)
    );
`else
    led_clk_divider #(.CLK_IN_HZ(8), .LED_HZ(1)) dut_a (
        .CLK_100MHz(clk), .RST(rst), .i_ce(ce),
        .CLK_LED(led_a)
    );
    led_clk_divider #(.CLK_IN_HZ(2), .LED_HZ(1)) dut_b (
        .CLK_100MHz(clk), .RST(rst), .i_ce(ce),
        .CLK_LED(led_b)
    );
    assign tick_a = 1'b0;
    assign tick_b = 1'b0;
`endif

    // Model: count enabled edges since reset; level = parity of e/HALF.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e    = 0;
            tk_a = 1'b0;
            tk_b = 1'b0;
        end else begin
            if (ce) e = e + 1;
            tk_a = ce && ((e % (2 * HA)) == HA);
            tk_b = ce && ((e % (2 * HB)) == HB);
        end
    end

    function automatic logic exp_led(input int cnt, input int h);
        return ((cnt / h) % 2) == 1;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_led_a", led_a, exp_led(e, HA));
        check("model_led_b", led_b, exp_led(e, HB));
`ifdef LED_CLK_TICK_EN
        check("model_tick_a", tick_a, tk_a);
        check("model_tick_b", tick_b, tk_b);
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset held for 10 cycles with enable high.
        ce = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("rst_hold", led_a, 1'b0);
        end
        rst = 1'b0;

        // Free-running: rise at 4, fall at 8, rise at 12.
        step(3);
        check("edge3_low", led_a, 1'b0);
        step(1);
        check("edge4_rise", led_a, 1'b1);
`ifdef LED_CLK_TICK_EN
        check("edge4_tick", tick_a, 1'b1);
`endif
        step(3);
        check("edge7_high", led_a, 1'b1);
        step(1);
        check("edge8_fall", led_a, 1'b0);
        step(4);
        check("edge12_rise", led_a, 1'b1);
`ifdef LED_CLK_TICK_EN
        check("edge12_tick", tick_a, 1'b1);
        step(1);
        check("edge13_notick", tick_a, 1'b0);
`endif

        // Enable dropped for 3 cycles after edge 2: rise moves to edge 7.
        do_reset();
        step(2);
        ce = 1'b0;
        step(3);
        check("stall_edge5", led_a, 1'b0);
        ce = 1'b1;
        step(1);
        check("stall_edge6", led_a, 1'b0);
        step(1);
        check("stall_edge7", led_a, 1'b1);

        // Async reset while high, between edges.
        do_reset();
        step(5);
        check("pre_rst_high", led_a, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", led_a, 1'b0);
        step(2);
        rst = 1'b0;
        step(3);
        check("post_rst_e3", led_a, 1'b0);
        step(1);
        check("post_rst_e4", led_a, 1'b1);

        // Divide-by-2 instance: 1,0,1,0.
        do_reset();
        step(1);
        check("half1_e1", led_b, 1'b1);
        step(1);
        check("half1_e2", led_b, 1'b0);
        step(1);
        check("half1_e3", led_b, 1'b1);
        step(1);
        check("half1_e4", led_b, 1'b0);

        // Random enable with occasional reset pulses.
        for (int i = 0; i < 800; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #($urandom_range(1, 3));
                rst = 1'b1;
                step(1 + $urandom_range(0, 1));
                rst = 1'b0;
            end else begin
                step(1);
            end
        end

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
